// File: rtl/traffic_light_controller_multi_if.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_multi_if
// Bundles the signals between the intersection sequencer and its neighbours.
// The `slave` modport belongs to the sequencer. The `master` modport belongs to
// the side that drives detector demand and reads the lamps.
//   demand      per-approach vehicle detect (level or 1-cycle pulse)
//   g_light     green lamp per approach
//   o_light     amber lamp per approach
//   r_light     red lamp per approach
//   active_dir  approach currently served
//   phase       0=GREEN 1=AMBER 2=ALL_RED
//   emerg_req   preemption request, level       (EMERG_PREEMPT_EN only)
//   emerg_dir   approach to preempt to          (EMERG_PREEMPT_EN only)
// Optional feature macro: EMERG_PREEMPT_EN
// -----------------------------------------------------------------------------
interface traffic_light_controller_multi_if #(
  parameter int N_DIR = 4,
  parameter int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1
);
  logic [N_DIR-1:0] demand;
  logic [N_DIR-1:0] g_light;
  logic [N_DIR-1:0] o_light;
  logic [N_DIR-1:0] r_light;
  logic [DIR_W-1:0] active_dir;
  logic [1:0]       phase;
`ifdef EMERG_PREEMPT_EN
  logic             emerg_req;
  logic [DIR_W-1:0] emerg_dir;

  modport master (output demand, emerg_req, emerg_dir,
                  input  g_light, o_light, r_light, active_dir, phase);
  modport slave  (input  demand, emerg_req, emerg_dir,
                  output g_light, o_light, r_light, active_dir, phase);
`else
  modport master (output demand,
                  input  g_light, o_light, r_light, active_dir, phase);
  modport slave  (input  demand,
                  output g_light, o_light, r_light, active_dir, phase);
`endif
endinterface

// File: rtl/traffic_light_controller_multi.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_multi
// N-approach intersection sequencer. Exactly one approach is served at a time,
// and each turn runs GREEN -> AMBER -> ALL_RED. Vehicle demand is latched per
// approach. Approaches without latched demand are skipped. When no other
// approach is waiting, the sequencer rests on green.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (released synchronously upstream)
//   tl     traffic_light_controller_multi_if.slave
//          (demand in, lamp vectors / active_dir / phase out)
// Optional feature macro: EMERG_PREEMPT_EN adds emergency preemption through
// tl.emerg_req / tl.emerg_dir.
// -----------------------------------------------------------------------------
module traffic_light_controller_multi #(
  parameter int N_DIR  = 4,
  parameter int TMR_W  = 10,
  parameter int G_TIME = 20,
  parameter int A_TIME = 5,
  parameter int R_TIME = 2
) (
  input logic                            clk,
  input logic                            rst_n,
  traffic_light_controller_multi_if.slave tl
);
  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_AMBER  = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  localparam logic [TMR_W-1:0] G_LOAD = TMR_W'(G_TIME - 1);
  localparam logic [TMR_W-1:0] A_LOAD = TMR_W'(A_TIME - 1);
  localparam logic [TMR_W-1:0] R_LOAD = TMR_W'(R_TIME - 1);

  phase_e           phase_q, phase_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [DIR_W-1:0] next_q, next_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [N_DIR-1:0] pend_q, pend_d;

  logic [N_DIR-2:0] pend_rot;
  logic             rr_hit;
  logic [DIR_W-1:0] rr_dir;

  // (d + k) mod N_DIR without a divider; the inputs never exceed 2*N_DIR-2.
  function automatic logic [DIR_W-1:0] wrap_add(logic [DIR_W-1:0] d, int k);
    logic [DIR_W:0] s;
    s = (DIR_W+1)'(d) + (DIR_W+1)'(k);
    if (s >= (DIR_W+1)'(N_DIR)) s = s - (DIR_W+1)'(N_DIR);
    return s[DIR_W-1:0];
  endfunction

  // Rotate the pending vector so that bit k-1 is approach active_dir+k.
  // Scanning k downward lets the nearest waiting approach win.
  always_comb begin
    pend_rot = (N_DIR-1)'({pend_q, pend_q} >> ((DIR_W+1)'(dir_q) + (DIR_W+1)'(1)));
    rr_hit   = 1'b0;
    rr_dir   = dir_q;
    for (int k = N_DIR - 1; k >= 1; k--) begin
      if (pend_rot[k-1]) begin
        rr_hit = 1'b1;
        rr_dir = wrap_add(dir_q, k);
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    next_d  = next_q;
    timer_d = timer_q - TMR_W'(1);
    pend_d  = pend_q | tl.demand;
    // The approach on green is being served, so its detector is ignored.
    if (phase_q == PH_GREEN) pend_d[dir_q] = 1'b0;

    case (phase_q)
      PH_GREEN: begin
        if (timer_q == '0) begin
          if (rr_hit) begin
            phase_d = PH_AMBER;
            next_d  = rr_dir;
            timer_d = A_LOAD;
          end else begin
            timer_d = G_LOAD;
          end
        end
      end
      PH_AMBER: begin
        if (timer_q == '0) begin
          phase_d = PH_ALLRED;
          timer_d = R_LOAD;
        end
      end
      PH_ALLRED: begin
        if (timer_q == '0) begin
          phase_d        = PH_GREEN;
          dir_d          = next_q;
          timer_d        = G_LOAD;
          pend_d[next_q] = 1'b0;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        timer_d = G_LOAD;
      end
    endcase

`ifdef EMERG_PREEMPT_EN
    // Preemption overrides the normal GREEN decision. AMBER and ALL_RED keep
    // their timing, and only the target approach is redirected.
    if (tl.emerg_req) begin
      if (phase_q == PH_GREEN) begin
        if (tl.emerg_dir == dir_q) begin
          phase_d = PH_GREEN;
          next_d  = next_q;
          timer_d = G_LOAD;
        end else begin
          phase_d = PH_AMBER;
          next_d  = tl.emerg_dir;
          timer_d = A_LOAD;
        end
      end else begin
        next_d = tl.emerg_dir;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      next_q  <= '0;
      timer_q <= G_LOAD;
      pend_q  <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      next_q  <= next_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  // Lamps are a pure decode of registered state. Only the active approach can
  // be non-red, so two greens are impossible by construction.
  assign tl.g_light    = (phase_q == PH_GREEN) ? (N_DIR'(1) << dir_q) : '0;
  assign tl.o_light    = (phase_q == PH_AMBER) ? (N_DIR'(1) << dir_q) : '0;
  assign tl.r_light    = ~(tl.g_light | tl.o_light);
  assign tl.active_dir = dir_q;
  assign tl.phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_controller_multi.sv
// -----------------------------------------------------------------------------
// Bench for traffic_light_controller_multi (4 approaches, 20/5/2 timing).
// The reference model describes a turn by the number of cycles elapsed since
// its green began and by the cycle at which green is due to end. Green
// extends in whole G-cycle blocks while resting. Directed scenarios pin the
// model with literal expectations; a random-demand run follows.
// -----------------------------------------------------------------------------
module tb_traffic_light_controller_multi;
  localparam int N = 4;
  localparam int G = 20;
  localparam int A = 5;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traffic_light_controller_multi_if #(.N_DIR(N)) tl ();

  traffic_light_controller_multi #(
    .N_DIR(N), .TMR_W(10), .G_TIME(G), .A_TIME(A), .R_TIME(R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tl    (tl)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int         el;    // cycles since this turn's green began
    int         gend;  // green occupies el < gend
    int         dir;
    int         nxt;
    logic [N-1:0] pend;
  } mst_t;

  localparam mst_t M_RST = '{el: 0, gend: G, dir: 0, nxt: 0, pend: '0};

  mst_t m;

  function automatic int m_phase(mst_t s);
    if (s.el < s.gend) return 0;
    if (s.el < s.gend + A) return 1;
    return 2;
  endfunction

  function automatic mst_t m_step(mst_t s, logic [N-1:0] d);
    mst_t n;
    int   ph;
    bit   found;
    n     = s;
    ph    = m_phase(s);
    n.pend = s.pend | d;
    if (ph == 0) n.pend[s.dir] = 1'b0;
    if (ph == 0 && s.el == s.gend - 1) begin
      found = 1'b0;
      for (int k = 1; k < N; k++) begin
        if (!found && s.pend[(s.dir + k) % N]) begin
          found = 1'b1;
          n.nxt = (s.dir + k) % N;
        end
      end
      if (!found) n.gend = s.gend + G;
      n.el = s.el + 1;
    end else if (ph == 2 && s.el == s.gend + A + R - 1) begin
      n.dir = s.nxt;
      n.el = 0;
      n.gend = G;
      n.pend[s.nxt] = 1'b0;
    end else begin
      n.el = s.el + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= m_step(m, tl.demand);
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [N-1:0] eg, eo, er;
      int ph;
      ph = m_phase(m);
      eg = (ph == 0) ? (N'(1) << m.dir) : '0;
      eo = (ph == 1) ? (N'(1) << m.dir) : '0;
      er = ~(eg | eo);
      checks++;
      if (tl.g_light !== eg || tl.o_light !== eo || tl.r_light !== er ||
          tl.phase !== 2'(ph) || tl.active_dir !== 2'(m.dir)) begin
        errors++;
        $display("FAIL model t=%0t got g=%b o=%b r=%b ph=%0d dir=%0d want g=%b o=%b r=%b ph=%0d dir=%0d",
                 $time, tl.g_light, tl.o_light, tl.r_light, tl.phase, tl.active_dir,
                 eg, eo, er, ph, m.dir);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller at a negedge with rst_n released: cycle 0 of a run.
  task automatic do_reset();
    tl.demand = '0;
    @(negedge clk);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [N-1:0] d);
    tl.demand = d;
    step(1);
    tl.demand = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    tl.demand = '0;
`ifdef EMERG_PREEMPT_EN
    tl.emerg_req = 1'b0;
    tl.emerg_dir = '0;
`endif

    // Idle after reset: rest on green for approach 0.
    do_reset();
    chk("rst_g", 32'(tl.g_light), 32'h1);
    chk("rst_o", 32'(tl.o_light), 32'h0);
    chk("rst_r", 32'(tl.r_light), 32'hE);
    chk("rst_phase", 32'(tl.phase), 32'd0);
    step(100);
    chk("idle_g", 32'(tl.g_light), 32'h1);
    chk("idle_r", 32'(tl.r_light), 32'hE);
    chk("idle_phase", 32'(tl.phase), 32'd0);

    // A single pulse on approach 2 at cycle 5.
    do_reset();
    step(4);
    pulse(4'b0100);
    step(14);
    chk("p2_c19_phase", 32'(tl.phase), 32'd0);
    step(1);
    chk("p2_c20_phase", 32'(tl.phase), 32'd1);
    chk("p2_c20_o", 32'(tl.o_light), 32'h1);
    step(5);
    chk("p2_c25_phase", 32'(tl.phase), 32'd2);
    chk("p2_c25_r", 32'(tl.r_light), 32'hF);
    step(2);
    chk("p2_c27_g", 32'(tl.g_light), 32'h4);
    chk("p2_c27_dir", 32'(tl.active_dir), 32'd2);

    // All approaches demanding continuously: strict rotation, 27 cycles per turn.
    do_reset();
    tl.demand = 4'b1111;
    for (int t = 1; t <= 4; t++) begin
      step(27);
      chk("rot_dir", 32'(tl.active_dir), 32'(t % N));
      chk("rot_phase", 32'(tl.phase), 32'd0);
    end
    tl.demand = '0;

    // From approach 3 with only approach 0 waiting: wrap, skipping 1 and 2.
    do_reset();
    pulse(4'b1000);
    step(26);
    chk("wrap_c27_dir", 32'(tl.active_dir), 32'd3);
    chk("wrap_c27_g", 32'(tl.g_light), 32'h8);
    step(3);
    pulse(4'b0001);
    step(16);
    chk("wrap_c47_phase", 32'(tl.phase), 32'd1);
    chk("wrap_c47_dir", 32'(tl.active_dir), 32'd3);
    step(7);
    chk("wrap_c54_dir", 32'(tl.active_dir), 32'd0);
    chk("wrap_c54_g", 32'(tl.g_light), 32'h1);

    // Asynchronous reset between edges in the middle of AMBER.
    do_reset();
    pulse(4'b0100);
    step(21);
    chk("ar_pre_phase", 32'(tl.phase), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_g", 32'(tl.g_light), 32'h1);
    chk("ar_o", 32'(tl.o_light), 32'h0);
    chk("ar_r", 32'(tl.r_light), 32'hE);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(4'b0010);
    step(18);
    chk("ar_c19_phase", 32'(tl.phase), 32'd0);
    step(1);
    chk("ar_c20_phase", 32'(tl.phase), 32'd1);
    step(7);
    chk("ar_c27_dir", 32'(tl.active_dir), 32'd1);

    // Random sparse demand, with one asynchronous reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] d;
      for (int b = 0; b < N; b++) d[b] = ($urandom_range(15) == 0);
      tl.demand = d;
      if (i == 1500) begin
        #(1 + $urandom_range(3)) rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end
    tl.demand = '0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
